// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Define DIV_EARLY_OUT_EN to let trivial divides (divisor 0 or |a| < |b|) skip the iterations.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT   = 3,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        req_ready,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] MulLastCnt = CntW'(MUL_LAT);
    localparam logic [CntW-1:0] DivLastCnt = CntW'(DIV_ITERS - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e          state_q, state_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     opa_q, opa_d, opb_q, opb_d;
    logic            sgn_q, sgn_d;
    logic [63:0]     rem_q, rem_d;
    logic [31:0]     dvs_q, dvs_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    logic        accept;
    logic        req_signed;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_a, mul_b, prod;
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [63:0] rem_step;
    logic [31:0] quot, remd;

    assign req_ready = (state_q == StIdle) && !flush;
    assign accept    = req_valid && req_ready;

    assign req_signed = (req_op == OpDiv);
    assign a_mag      = (req_signed && a[31]) ? -a : a;
    assign b_mag      = (req_signed && b[31]) ? -b : b;

    // Low 64 bits of the product of 64-bit extended operands are correct for both signednesses.
    assign mul_a = {{32{sgn_q & opa_q[31]}}, opa_q};
    assign mul_b = {{32{sgn_q & opb_q[31]}}, opb_q};
    assign prod  = mul_a * mul_b;

    // One restoring step: shift, trial-subtract the divisor from the upper half, keep if non-negative.
    assign shifted  = {rem_q, 1'b0};
    assign trial    = shifted[64:32] - {1'b0, dvs_q};
    assign rem_step = trial[32] ? shifted[63:0] : {trial[31:0], shifted[31:1], 1'b1};

    assign quot = rem_q[31:0];
    assign remd = rem_q[63:32];

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (req_op)
                        OpMult, OpMultu: begin
                            opa_d   = a;
                            opb_d   = b;
                            sgn_d   = (req_op == OpMult);
                            cnt_d   = CntW'(1);
                            state_d = StMul;
                        end
                        OpDiv, OpDivu: begin
                            opa_d   = a;
                            sgn_d   = req_signed;
                            rem_d   = {32'd0, a_mag};
                            dvs_d   = b_mag;
                            q_neg_d = req_signed && (a[31] ^ b[31]);
                            r_neg_d = req_signed && a[31];
                            cnt_d   = '0;
                            state_d = StDiv;
`ifdef DIV_EARLY_OUT_EN
                            if (b_mag == 32'd0) begin
                                rem_d   = {a_mag, 32'hFFFF_FFFF};
                                state_d = StFix;
                            end else if (a_mag < b_mag) begin
                                rem_d   = {a_mag, 32'd0};
                                state_d = StFix;
                            end
`endif
                        end
                        OpMthi:  hi_d = a;
                        OpMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == MulLastCnt) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = rem_step;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == DivLastCnt) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (dvs_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = opa_q;
                    end else begin
                        lo_d = q_neg_q ? -quot : quot;
                        hi_d = r_neg_q ? -remd : remd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected {hi,lo} queued at issue, checked on every done pulse.
module tb_muldiv_ctrl;

    localparam int unsigned MUL_LAT = 3;
    localparam int MulLat  = MUL_LAT + 1;  // negedges after the accept edge until done is seen
    localparam int DivLat  = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int DivLatShort = 2;
`else
    localparam int DivLatShort = 34;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, req_valid;
    logic [2:0]  req_op;
    logic [31:0] a, b;
    logic        req_ready, done;
    logic [31:0] hi, lo;

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_op    (req_op),
        .a         (a),
        .b         (b),
        .req_ready (req_ready),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: hi=%h lo=%h, expected no done", hi, lo);
            end else begin
                check("hilo_on_done", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        req_valid = 1'b1;
        req_op    = op;
        a         = av;
        b         = bv;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (lat < budget) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        issue(op, av, bv);
        wait_done(60, lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_done",  64'(done),      64'd0);
        check("reset_hilo",  {hi, lo},       64'd0);

        // DIVU 100/7 with ready/done timing across E1..E33
        exp_q.push_back({32'd2, 32'd14});
        issue(3'd3, 32'd100, 32'd7);
        d0 = done_cnt;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            check("divu_busy_ready", 64'(req_ready), 64'd0);
        end
        check("divu_no_early_done", 64'(done_cnt), 64'(d0));
        @(negedge clk);
        check("divu_done_e33",  64'(done),      64'd1);
        check("divu_ready_e33", 64'(req_ready), 64'd1);

        run_op("div_neg7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DivLat);
        run_op("div_ovf",      3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, DivLat);
        run_op("mult_m1x2",    3'd0, 32'hFFFF_FFFF, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFE}, MulLat);
        run_op("multu_x2",     3'd1, 32'hFFFF_FFFF, 32'd2,
               {32'd1, 32'hFFFF_FFFE}, MulLat);
        run_op("mult_negneg",  3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
               {32'd0, 32'd6}, MulLat);
        run_op("multu_big",    3'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
               {32'hFFFF_FFFB, 32'd6}, MulLat);
        run_op("divu_by0",     3'd3, 32'd5, 32'd0,
               {32'd5, 32'hFFFF_FFFF}, DivLatShort);
        run_op("div_neg_by0",  3'd2, 32'hFFFF_FFFB, 32'd0,
               {32'hFFFF_FFFB, 32'hFFFF_FFFF}, DivLatShort);
        run_op("div_small",    3'd2, 32'd3, 32'hFFFF_FFF6,
               {32'd3, 32'd0}, DivLatShort);
        run_op("div_negsmall", 3'd2, 32'hFFFF_FFFD, 32'd10,
               {32'hFFFF_FFFD, 32'd0}, DivLatShort);

        // MTHI then MTLO back to back
        @(negedge clk);
        d0 = done_cnt;
        req_valid = 1'b1; req_op = 3'd4; a = 32'h1234;
        @(posedge clk);
        #1 req_op = 3'd5; a = 32'h5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mt_hilo",  {hi, lo}, {32'h1234, 32'h5678});
        check("mt_ready", 64'(req_ready), 64'd1);
        check("mt_no_done", 64'(done_cnt), 64'(d0));

        // Flush while idle blocks the request
        req_valid = 1'b1; req_op = 3'd4; a = 32'hDEAD; flush = 1'b1;
        #1 check("flush_idle_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_hi", 64'(hi), 64'h1234);

        // Flush a DIVU at E10
        d0 = done_cnt;
        issue(3'd3, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_div_ready", 64'(req_ready), 64'd1);
        repeat (40) @(negedge clk);
        check("flush_div_no_done", 64'(done_cnt), 64'(d0));
        check("flush_div_hilo", {hi, lo}, {32'h1234, 32'h5678});

        // Reset in the middle of a MULT
        issue(3'd0, 32'd7, 32'd9);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mul_hilo",  {hi, lo}, 64'd0);
        check("rst_mul_ready", 64'(req_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("rst_mul_no_done", 64'(done_cnt), 64'(d0));
        check("rst_mul_hilo_late", {hi, lo}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_cnt), 64'd11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
